// File: rtl/pc_unit_if.sv
// Instruction-fetch request channel between the PC unit and instruction memory.
// Master drives the fetch address and valid; slave answers with ready.
interface pc_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] PC_Out;
    logic [XLEN-1:0] PC_Next_Seq;
    logic            Fetch_Valid;
    logic            Fetch_Ready;

    modport master (
        output PC_Out,
        output PC_Next_Seq,
        output Fetch_Valid,
        input  Fetch_Ready
    );

    modport slave (
        input  PC_Out,
        input  PC_Next_Seq,
        input  Fetch_Valid,
        output Fetch_Ready
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter: issues PC over a valid/ready handshake and picks the next PC
// from trap vector, redirect, a one-entry pending queue, or sequential increment.
module pc_unit #(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_VEC  = '0,
    parameter int unsigned      INC        = 4,
    parameter int unsigned      ALIGN_BITS = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            Stall,
    input  logic            Redirect_En,
    input  logic [XLEN-1:0] Redirect_PC,
    input  logic            Trap_En,
    input  logic [XLEN-1:0] Trap_Vec,
    input  logic            Halt_Req,
    input  logic            Resume,
    output logic            Misalign_Flt,
    output logic [XLEN-1:0] Fault_PC,
    pc_unit_if.master       fetch
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);
    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALTED
    } state_e;

    typedef enum logic [1:0] {
        Q_NONE,
        Q_REDIRECT,
        Q_TRAP
    } qtag_e;

    state_e          state_q, state_d;
    qtag_e           q_tag_q, q_tag_d;
    logic [XLEN-1:0] q_pc_q, q_pc_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            held_q;
    logic            misalign_q;
    logic [XLEN-1:0] fault_q;

    logic            fetch_valid;
    logic            accept;
    logic            outstanding;
    logic            misaligned;
    logic            redirect_ok;
    logic [XLEN-1:0] trap_target;

    assign fetch_valid = (state_q == ST_RUN) && (held_q || (!Stall && !Halt_Req));
    assign accept      = fetch_valid && fetch.Fetch_Ready;
    // A request still unaccepted after this edge must keep its address, so new targets are
    // parked in the queue instead of touching the PC.
    assign outstanding = fetch_valid && !fetch.Fetch_Ready;
    assign misaligned  = (Redirect_PC & ALIGN_MASK) != '0;
    assign redirect_ok = Redirect_En && !misaligned;
    assign trap_target = Trap_Vec & ~ALIGN_MASK;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (Halt_Req && !outstanding) state_d = ST_HALTED;
            ST_HALTED: if (Resume || Trap_En) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        q_tag_d = q_tag_q;
        q_pc_d  = q_pc_q;
        if (outstanding) begin
            // A trap always claims the slot; a redirect never displaces a queued trap.
            if (Trap_En) begin
                q_tag_d = Q_TRAP;
                q_pc_d  = trap_target;
            end else if (redirect_ok && q_tag_q != Q_TRAP) begin
                q_tag_d = Q_REDIRECT;
                q_pc_d  = Redirect_PC;
            end
        end else begin
            q_tag_d = Q_NONE;
            if (Trap_En)                pc_d = trap_target;
            else if (redirect_ok)       pc_d = Redirect_PC;
            else if (q_tag_q != Q_NONE) pc_d = q_pc_q;
            else if (accept)            pc_d = pc_q + INC_V;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            q_tag_q    <= Q_NONE;
            q_pc_q     <= '0;
            held_q     <= 1'b0;
            misalign_q <= 1'b0;
            fault_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update
            // from the same pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            q_tag_q    <= q_tag_d;
            q_pc_q     <= q_pc_d;
            held_q     <= outstanding;
            misalign_q <= Redirect_En && misaligned && !Trap_En;
            if (Redirect_En && misaligned && !Trap_En) fault_q <= Redirect_PC;
        end
    end

    assign fetch.PC_Out      = pc_q;
    assign fetch.PC_Next_Seq = pc_q + INC_V;
    assign fetch.Fetch_Valid = fetch_valid;
    assign Misalign_Flt      = misalign_q;
    assign Fault_PC          = fault_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, reset-mid-handshake sequence,
// and randomized traffic against a queue-based behavioural model.
module tb_pc_unit;

    logic        CLK;
    logic        RST_N;
    logic        Stall, Redirect_En, Trap_En, Halt_Req, Resume;
    logic [31:0] Redirect_PC, Trap_Vec, Fault_PC;
    logic        Misalign_Flt;

    pc_unit_if #(.XLEN(32)) fif ();

    pc_unit #(.XLEN(32), .RESET_VEC(32'h0), .INC(4), .ALIGN_BITS(2)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .Stall        (Stall),
        .Redirect_En  (Redirect_En),
        .Redirect_PC  (Redirect_PC),
        .Trap_En      (Trap_En),
        .Trap_Vec     (Trap_Vec),
        .Halt_Req     (Halt_Req),
        .Resume       (Resume),
        .Misalign_Flt (Misalign_Flt),
        .Fault_PC     (Fault_PC),
        .fetch        (fif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          stall, ready, ren, ten, halt, resume;
        logic [31:0] rpc, tvec;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] pc;
        bit          valid, flt;
        logic [31:0] fault;
    } row_t;

    typedef struct packed {
        logic        is_trap;
        logic [31:0] pc;
    } pend_t;

    row_t  rows[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Behavioural model state
    int          m_mode;   // 0 booting, 1 running, 2 halted
    logic [31:0] m_pc, m_fault;
    bit          m_flt, m_stuck;
    pend_t       pend_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(bit stall, bit ready, bit ren, logic [31:0] rpc, bit ten,
                                logic [31:0] tvec, bit halt, bit resume,
                                logic [31:0] pc, bit valid, bit flt, logic [31:0] fault);
        row_t r;
        r.in.stall = stall; r.in.ready = ready; r.in.ren = ren; r.in.rpc = rpc;
        r.in.ten = ten; r.in.tvec = tvec; r.in.halt = halt; r.in.resume = resume;
        r.pc = pc; r.valid = valid; r.flt = flt; r.fault = fault;
        rows.push_back(r);
    endfunction

    task automatic drive(input in_t i);
        Stall = i.stall; fif.Fetch_Ready = i.ready;
        Redirect_En = i.ren; Redirect_PC = i.rpc;
        Trap_En = i.ten; Trap_Vec = i.tvec;
        Halt_Req = i.halt; Resume = i.resume;
    endtask

    task automatic check_outs(input string tag, input logic [31:0] pc, input bit valid,
                              input bit flt, input logic [31:0] fault);
        check({tag, " pc"},    fif.PC_Out,              pc);
        check({tag, " seq"},   fif.PC_Next_Seq,         pc + 32'd4);
        check({tag, " valid"}, 32'(fif.Fetch_Valid),    32'(valid));
        check({tag, " flt"},   32'(Misalign_Flt),       32'(flt));
        check({tag, " fault"}, Fault_PC,                fault);
    endtask

    // Advances the model by one clock edge given this cycle's inputs.
    function automatic void model_step(input in_t i);
        bit          valid, stuck_now, mis, ok, has_trap;
        logic [31:0] tgt;
        valid     = (m_mode == 1) && (m_stuck || (!i.stall && !i.halt));
        stuck_now = valid && !i.ready;
        mis       = i.ren && (i.rpc % 4 != 0);
        ok        = i.ren && !mis;
        tgt       = (i.tvec / 4) * 4;
        has_trap  = (pend_q.size() > 0) && pend_q[0].is_trap;
        if (stuck_now) begin
            if (i.ten) begin
                pend_q.delete();
                pend_q.push_back(pend_t'{is_trap: 1'b1, pc: tgt});
            end else if (ok && !has_trap) begin
                pend_q.delete();
                pend_q.push_back(pend_t'{is_trap: 1'b0, pc: i.rpc});
            end
        end else begin
            if (i.ten)                 m_pc = tgt;
            else if (ok)               m_pc = i.rpc;
            else if (pend_q.size() > 0) m_pc = pend_q[0].pc;
            else if (valid && i.ready) m_pc = m_pc + 32'd4;
            pend_q.delete();
        end
        m_flt = mis && !i.ten;
        if (m_flt) m_fault = i.rpc;
        if (m_mode == 0)                          m_mode = 1;
        else if (m_mode == 1 && i.halt && !stuck_now) m_mode = 2;
        else if (m_mode == 2 && (i.resume || i.ten))  m_mode = 1;
        m_stuck = stuck_now;
    endfunction

    function automatic bit model_valid(input in_t i);
        return (m_mode == 1) && (m_stuck || (!i.stall && !i.halt));
    endfunction

    initial begin
        in_t idle;
        idle = '{default: 0};
        RST_N = 1'b0;
        drive(idle);

        //  stall rdy ren rpc          ten tvec          halt res  pc            v  f  fault
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0);  // boot
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0);
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h4,        1, 0, 32'h0);
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h8,        1, 0, 32'h0);
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'hC,        1, 0, 32'h0);
        add(1, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h10,       0, 0, 32'h0);
        add(1, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h10,       0, 0, 32'h0);
        add(0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h10,       1, 0, 32'h0);  // issue, stuck
        add(1, 0, 1, 32'h100, 0, 32'h0,        0, 0, 32'h10,       1, 0, 32'h0);  // queued redirect
        add(1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h10,       1, 0, 32'h0);
        add(1, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h10,       1, 0, 32'h0);  // accept
        add(1, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h100,      0, 0, 32'h0);
        add(1, 0, 1, 32'h40,  1, 32'h203,      0, 0, 32'h100,      0, 0, 32'h0);  // trap beats redirect
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h200,      1, 0, 32'h0);
        add(0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h204,      1, 0, 32'h0);
        add(0, 0, 0, 32'h0,   1, 32'h300,      0, 0, 32'h204,      1, 0, 32'h0);  // queued trap
        add(0, 0, 1, 32'h80,  0, 32'h0,        0, 0, 32'h204,      1, 0, 32'h0);  // redirect ignored
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h204,      1, 0, 32'h0);
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h300,      1, 0, 32'h0);
        add(0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h304,      1, 0, 32'h0);
        add(0, 0, 1, 32'h500, 0, 32'h0,        0, 0, 32'h304,      1, 0, 32'h0);
        add(0, 0, 0, 32'h0,   1, 32'h600,      0, 0, 32'h304,      1, 0, 32'h0);  // trap overwrites
        add(0, 1, 1, 32'h700, 0, 32'h0,        0, 0, 32'h304,      1, 0, 32'h0);  // live redirect wins
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h700,      1, 0, 32'h0);
        add(0, 1, 1, 32'h42,  0, 32'h0,        0, 0, 32'h704,      1, 0, 32'h0);  // misaligned
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h708,      1, 1, 32'h42);
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h70C,      1, 0, 32'h42);
        add(1, 0, 1, 32'h43,  1, 32'h800,      0, 0, 32'h710,      0, 0, 32'h42);  // trap masks fault
        add(1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h800,      0, 0, 32'h42);
        add(0, 1, 0, 32'h0,   0, 32'h0,        1, 0, 32'h800,      0, 0, 32'h42);  // halt
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h800,      0, 0, 32'h42);
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 1, 32'h800,      0, 0, 32'h42);  // resume
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h800,      1, 0, 32'h42);
        add(0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h804,      1, 0, 32'h42);
        add(0, 0, 0, 32'h0,   0, 32'h0,        1, 0, 32'h804,      1, 0, 32'h42);  // halt waits
        add(0, 1, 0, 32'h0,   0, 32'h0,        1, 0, 32'h804,      1, 0, 32'h42);
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h808,      0, 0, 32'h42);
        add(0, 1, 0, 32'h0,   1, 32'hFFFF_FFFF, 0, 0, 32'h808,     0, 0, 32'h42);  // trap leaves halt
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'hFFFF_FFFC, 1, 0, 32'h42);
        add(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h42);  // wrapped

        repeat (2) @(negedge CLK);
        #1;
        check_outs("reset", 32'h0, 0, 0, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int r = 0; r < rows.size(); r++) begin
            drive(rows[r].in);
            #1;
            check_outs($sformatf("row%0d", r), rows[r].pc, rows[r].valid, rows[r].flt,
                       rows[r].fault);
            @(negedge CLK);
        end

        // Reset in the middle of a stalled handshake with a redirect queued.
        begin
            in_t s;
            s = idle;
            drive(s);
            #1;
            check_outs("rst_a", 32'h4, 1, 0, 32'h42);
            @(negedge CLK);
            s.ren = 1; s.rpc = 32'h900;
            drive(s);
            #1;
            check_outs("rst_b", 32'h4, 1, 0, 32'h42);
            #2;
            RST_N = 1'b0;
            #1;
            check_outs("rst_async", 32'h0, 0, 0, 32'h0);
            @(negedge CLK);
            @(negedge CLK);
            RST_N = 1'b1;
            s = idle; s.ready = 1;
            drive(s);
            #1;
            check_outs("rst_boot", 32'h0, 0, 0, 32'h0);
            @(negedge CLK);
            #1;
            check_outs("rst_run", 32'h0, 1, 0, 32'h0);
            @(negedge CLK);
            #1;
            check_outs("rst_noq", 32'h4, 1, 0, 32'h0);
        end

        // Randomized traffic against the behavioural model.
        @(negedge CLK);
        RST_N = 1'b0;
        drive(idle);
        @(negedge CLK);
        RST_N = 1'b1;
        m_mode = 0; m_pc = 32'h0; m_fault = 32'h0; m_flt = 0; m_stuck = 0;
        pend_q.delete();
        for (int c = 0; c < 600; c++) begin
            in_t i;
            i.stall  = ($urandom_range(0, 3) == 0);
            i.ready  = ($urandom_range(0, 9) < 6);
            i.ren    = ($urandom_range(0, 4) == 0);
            i.rpc    = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 3) == 0) i.rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) i.rpc = 32'hFFFF_FFFC;
            i.ten    = ($urandom_range(0, 19) == 0);
            i.tvec   = $urandom & 32'h0000_FFFF;
            i.halt   = ($urandom_range(0, 11) == 0);
            i.resume = ($urandom_range(0, 3) == 0);
            drive(i);
            #1;
            check_outs($sformatf("rnd%0d", c), m_pc, model_valid(i), m_flt, m_fault);
            model_step(i);
            @(negedge CLK);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
